// File: rtl/mip_vram_pkg.sv
// mip_vram_pkg: shared definitions for the maximum-intensity-projection frame store.
//   - default screen geometry and BRAM read latency
//   - pixels packed per 64-bit BRAM word
//   - RMW/clear FSM state encoding
//   - ray-calc sample record {x, y, density}
//   - saturating 8-bit add used by the optional accumulate combine rule
package mip_vram_pkg;

    localparam int SCR_W_DEF    = 640;
    localparam int SCR_H_DEF    = 480;
    localparam int RD_LAT_DEF   = 2;
    localparam int PIX_PER_WORD = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_WRITE = 3'd3,
        ST_CLEAR = 3'd4
    } state_e;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic [7:0] density;
    } sample_t;

    // min(a+b, 255) on 8-bit intensities
    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

endpackage

// File: rtl/mip_rr_arbiter.sv
// mip_rr_arbiter: 4-way round-robin request picker.
//   req_i      : per-channel request (queue non-empty)
//   ptr_i      : channel with highest priority this cycle
//   gnt_o      : one-hot grant (all zero when no request)
//   gnt_idx_o  : index of the granted channel
//   gnt_vld_o  : any request present
// Purely combinational; the caller registers the grant and advances the pointer.
module mip_rr_arbiter (
    input  logic [3:0] req_i,
    input  logic [1:0] ptr_i,
    output logic [3:0] gnt_o,
    output logic [1:0] gnt_idx_o,
    output logic       gnt_vld_o
);

    logic [7:0] req_dbl_s;
    logic [3:0] req_rot_s;
    logic [1:0] pos_s;

    // Rotate requests so the pointer channel sits at bit 0, then pick the lowest set bit
    always_comb begin
        req_dbl_s = {req_i, req_i} >> ptr_i;
        req_rot_s = req_dbl_s[3:0];
        casez (req_rot_s)
            4'b???1: pos_s = 2'd0;
            4'b??10: pos_s = 2'd1;
            4'b?100: pos_s = 2'd2;
            4'b1000: pos_s = 2'd3;
            default: pos_s = 2'd0;
        endcase
        gnt_vld_o = |req_i;
        gnt_idx_o = ptr_i + pos_s;
        gnt_o     = gnt_vld_o ? (4'b0001 << gnt_idx_o) : 4'b0000;
    end

endmodule

// File: rtl/mip_vram.sv
// mip_vram: maximum-intensity-projection frame store.
// Pops (x,y,density) samples from four FWFT result queues in round-robin order and
// read-modify-writes one 8-bit pixel lane of a 64-bit BRAM word (stored = max(stored,new)).
// A level-sensitive clear request sweeps the whole frame to zero while busy is high.
// Ports:
//   clock, reset                       clock and asynchronous active-low reset
//   io_calc_res_N_*  (N=0..3)          queue valid/pop strobe and sample fields
//   io_ram_port_*                      64-bit BRAM port (word address, byte-lane write enable)
//   io_ram_reset / io_ram_reset_busy   frame-clear request / clear sweep in progress
// Build option: define MIP_VRAM_SAT_ADD_EN to combine with a saturating add instead of max.
module mip_vram
    import mip_vram_pkg::*;
#(
    parameter int SCR_W  = SCR_W_DEF,
    parameter int SCR_H  = SCR_H_DEF,
    parameter int RD_LAT = RD_LAT_DEF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        io_calc_res_0_data_valid,
    output logic        io_calc_res_0_rden,
    input  logic [9:0]  io_calc_res_0_screen_pos_x,
    input  logic [9:0]  io_calc_res_0_screen_pos_y,
    input  logic [7:0]  io_calc_res_0_density,
    input  logic        io_calc_res_1_data_valid,
    output logic        io_calc_res_1_rden,
    input  logic [9:0]  io_calc_res_1_screen_pos_x,
    input  logic [9:0]  io_calc_res_1_screen_pos_y,
    input  logic [7:0]  io_calc_res_1_density,
    input  logic        io_calc_res_2_data_valid,
    output logic        io_calc_res_2_rden,
    input  logic [9:0]  io_calc_res_2_screen_pos_x,
    input  logic [9:0]  io_calc_res_2_screen_pos_y,
    input  logic [7:0]  io_calc_res_2_density,
    input  logic        io_calc_res_3_data_valid,
    output logic        io_calc_res_3_rden,
    input  logic [9:0]  io_calc_res_3_screen_pos_x,
    input  logic [9:0]  io_calc_res_3_screen_pos_y,
    input  logic [7:0]  io_calc_res_3_density,
    output logic [63:0] io_ram_port_addra,
    output logic [63:0] io_ram_port_dina,
    input  logic [63:0] io_ram_port_douta,
    output logic        io_ram_port_ena,
    output logic [7:0]  io_ram_port_wea,
    input  logic        io_ram_reset,
    output logic        io_ram_reset_busy
);

    localparam int DEPTH = SCR_W * SCR_H / PIX_PER_WORD;

    sample_t     smp_s [4];
    sample_t     sel_s;
    logic [3:0]  req_s;
    logic [3:0]  gnt_s;
    logic [1:0]  gnt_idx_s;
    logic        gnt_vld_s;
    logic [18:0] pix_s;
    logic        in_range_s;
    logic [7:0]  old_s;
    logic [7:0]  new_s;
    logic        do_write_s;

    state_e      state_q;
    logic [1:0]  ptr_q;
    logic [3:0]  rden_q;
    logic [7:0]  density_q;
    logic [15:0] word_q;
    logic [2:0]  lane_q;
    logic [3:0]  wait_q;
    logic [15:0] addra_q;
    logic [63:0] dina_q;
    logic        ena_q;
    logic [7:0]  wea_q;
    logic        busy_q;

    assign smp_s[0] = '{x: io_calc_res_0_screen_pos_x, y: io_calc_res_0_screen_pos_y, density: io_calc_res_0_density};
    assign smp_s[1] = '{x: io_calc_res_1_screen_pos_x, y: io_calc_res_1_screen_pos_y, density: io_calc_res_1_density};
    assign smp_s[2] = '{x: io_calc_res_2_screen_pos_x, y: io_calc_res_2_screen_pos_y, density: io_calc_res_2_density};
    assign smp_s[3] = '{x: io_calc_res_3_screen_pos_x, y: io_calc_res_3_screen_pos_y, density: io_calc_res_3_density};
    assign req_s    = {io_calc_res_3_data_valid, io_calc_res_2_data_valid,
                       io_calc_res_1_data_valid, io_calc_res_0_data_valid};

    mip_rr_arbiter u_arb (
        .req_i     (req_s),
        .ptr_i     (ptr_q),
        .gnt_o     (gnt_s),
        .gnt_idx_o (gnt_idx_s),
        .gnt_vld_o (gnt_vld_s)
    );

    // Granted sample: pixel index, range check, and combine of the read-back lane
    always_comb begin
        sel_s      = smp_s[gnt_idx_s];
        pix_s      = 19'(sel_s.y) * 19'(SCR_W) + 19'(sel_s.x);
        in_range_s = (sel_s.x < 10'(SCR_W)) && (sel_s.y < 10'(SCR_H));
        old_s      = io_ram_port_douta[{lane_q, 3'b000} +: 8];
`ifdef MIP_VRAM_SAT_ADD_EN
        new_s      = sat_add8(old_s, density_q);
        do_write_s = (density_q != 8'd0);
`else
        new_s      = density_q;
        do_write_s = (density_q > old_s);
`endif
    end

    // RMW / clear FSM with all port outputs registered
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            ptr_q     <= 2'd0;
            rden_q    <= 4'b0000;
            density_q <= 8'd0;
            word_q    <= 16'd0;
            lane_q    <= 3'd0;
            wait_q    <= 4'd0;
            addra_q   <= 16'd0;
            dina_q    <= 64'd0;
            ena_q     <= 1'b0;
            wea_q     <= 8'h00;
            busy_q    <= 1'b0;
        end else begin
            rden_q <= 4'b0000;
            case (state_q)
                ST_IDLE: begin
                    ena_q <= 1'b0;
                    wea_q <= 8'h00;
                    if (io_ram_reset) begin
                        state_q <= ST_CLEAR;
                        addra_q <= 16'd0;
                        dina_q  <= 64'd0;
                        ena_q   <= 1'b1;
                        wea_q   <= 8'hFF;
                        busy_q  <= 1'b1;
                    // While a pop strobe is out the queue head is stale, so hold off one cycle
                    end else if (gnt_vld_s && (rden_q == 4'b0000)) begin
                        rden_q    <= gnt_s;
                        ptr_q     <= gnt_idx_s + 2'd1;
                        density_q <= sel_s.density;
                        word_q    <= pix_s[18:3];
                        lane_q    <= pix_s[2:0];
                        if (in_range_s) begin
                            state_q <= ST_READ;
                            ena_q   <= 1'b1;
                            addra_q <= pix_s[18:3];
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_READ: begin
                    ena_q   <= 1'b0;
                    wait_q  <= 4'(RD_LAT - 1);
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    // douta for the READ-cycle address is valid in the final WAIT cycle
                    if (wait_q == 4'd0) begin
                        state_q <= ST_WRITE;
                        addra_q <= word_q;
                        if (do_write_s) begin
                            ena_q  <= 1'b1;
                            wea_q  <= 8'b0000_0001 << lane_q;
                            dina_q <= 64'(new_s) << {lane_q, 3'b000};
                        end else begin
                            ena_q  <= 1'b0;
                            wea_q  <= 8'h00;
                        end
                    end else begin
                        wait_q <= wait_q - 4'd1;
                    end
                end
                ST_WRITE: begin
                    ena_q   <= 1'b0;
                    wea_q   <= 8'h00;
                    state_q <= ST_IDLE;
                end
                ST_CLEAR: begin
                    if (addra_q == 16'(DEPTH - 1)) begin
                        state_q <= ST_IDLE;
                        ena_q   <= 1'b0;
                        wea_q   <= 8'h00;
                        busy_q  <= 1'b0;
                    end else begin
                        addra_q <= addra_q + 16'd1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    ena_q   <= 1'b0;
                    wea_q   <= 8'h00;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign io_calc_res_0_rden = rden_q[0];
    assign io_calc_res_1_rden = rden_q[1];
    assign io_calc_res_2_rden = rden_q[2];
    assign io_calc_res_3_rden = rden_q[3];
    assign io_ram_port_addra  = {48'd0, addra_q};
    assign io_ram_port_dina   = dina_q;
    assign io_ram_port_ena    = ena_q;
    assign io_ram_port_wea    = wea_q;
    assign io_ram_reset_busy  = busy_q;

endmodule

// File: tb/tb_mip_vram.sv
// tb_mip_vram: self-checking bench for mip_vram with FWFT queue models and a
// 2-cycle-latency 38400x64 BRAM model. Single-sample cases are table driven;
// clear sweep, arbitration fairness and clear-during-RMW are hand sequences.
module tb_mip_vram;

    localparam int DEPTH = 38400;

    logic        clock;
    logic        reset;
    logic        vld [4];
    logic [9:0]  px  [4];
    logic [9:0]  py  [4];
    logic [7:0]  pd  [4];
    wire  [3:0]  rden;
    wire  [63:0] addra;
    wire  [63:0] dina;
    logic [63:0] douta;
    wire         ena;
    wire  [7:0]  wea;
    logic        ram_rst;
    wire         busy;

    mip_vram dut (
        .clock(clock), .reset(reset),
        .io_calc_res_0_data_valid(vld[0]), .io_calc_res_0_rden(rden[0]),
        .io_calc_res_0_screen_pos_x(px[0]), .io_calc_res_0_screen_pos_y(py[0]), .io_calc_res_0_density(pd[0]),
        .io_calc_res_1_data_valid(vld[1]), .io_calc_res_1_rden(rden[1]),
        .io_calc_res_1_screen_pos_x(px[1]), .io_calc_res_1_screen_pos_y(py[1]), .io_calc_res_1_density(pd[1]),
        .io_calc_res_2_data_valid(vld[2]), .io_calc_res_2_rden(rden[2]),
        .io_calc_res_2_screen_pos_x(px[2]), .io_calc_res_2_screen_pos_y(py[2]), .io_calc_res_2_density(pd[2]),
        .io_calc_res_3_data_valid(vld[3]), .io_calc_res_3_rden(rden[3]),
        .io_calc_res_3_screen_pos_x(px[3]), .io_calc_res_3_screen_pos_y(py[3]), .io_calc_res_3_density(pd[3]),
        .io_ram_port_addra(addra), .io_ram_port_dina(dina), .io_ram_port_douta(douta),
        .io_ram_port_ena(ena), .io_ram_port_wea(wea),
        .io_ram_reset(ram_rst), .io_ram_reset_busy(busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- BRAM model: read data valid 2 cycles after ena ----------------
    logic [63:0] mem [DEPTH];
    logic [63:0] rd1;
    always @(posedge clock) begin
        if (ena && addra < 64'(DEPTH)) begin
            for (int b = 0; b < 8; b++)
                if (wea[b]) mem[addra[15:0]][8*b +: 8] <= dina[8*b +: 8];
            rd1 <= mem[addra[15:0]];
        end
        douta <= rd1;
    end

    // ---------------- FWFT queue models ----------------
    typedef struct { int x; int y; int d; } smp_t;
    smp_t qs [4][$];

    task automatic refresh();
        for (int i = 0; i < 4; i++) begin
            if (qs[i].size() > 0) begin
                vld[i] = 1'b1; px[i] = 10'(qs[i][0].x); py[i] = 10'(qs[i][0].y); pd[i] = 8'(qs[i][0].d);
            end else begin
                vld[i] = 1'b0; px[i] = 10'd0; py[i] = 10'd0; pd[i] = 8'd0;
            end
        end
    endtask

    task automatic push(input int ch, input int x, input int y, input int d);
        smp_t s;
        s.x = x; s.y = y; s.d = d;
        qs[ch].push_back(s);
        refresh();
    endtask

    // ---------------- monitor (negedge) and queue pop ----------------
    typedef struct packed { logic [15:0] a; logic [7:0] w; logic [63:0] d; } wr_t;
    int          grant_ch  [$];
    longint      grant_cyc [$];
    logic [15:0] rd_addr   [$];
    wr_t         wr_log    [$];
    int          multi_err;
    longint      cyc;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if ($countones(rden) > 1) multi_err++;
        for (int i = 0; i < 4; i++)
            if (rden[i]) begin grant_ch.push_back(i); grant_cyc.push_back(cyc); end
        if (ena && !busy && wea == 8'h00) rd_addr.push_back(addra[15:0]);
        if (ena && !busy && wea != 8'h00) wr_log.push_back('{addra[15:0], wea, dina});
        for (int i = 0; i < 4; i++)
            if (rden[i] && qs[i].size() > 0) void'(qs[i].pop_front());
        refresh();
    end

    // ---------------- checking ----------------
    int checks;
    int errors;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_logs();
        grant_ch.delete(); grant_cyc.delete(); rd_addr.delete(); wr_log.delete();
    endtask

    typedef struct {
        int          ch; int x; int y; int d;
        bit          exp_rd; bit exp_wr;
        logic [15:0] exp_addr; logic [7:0] exp_wea; logic [63:0] exp_dina;
    } vec_t;
    vec_t vecs [9];

    task automatic apply_vec(input int idx);
        vec_t v;
        v = vecs[idx];
        clear_logs();
        @(negedge clock);
        push(v.ch, v.x, v.y, v.d);
        repeat (12) @(negedge clock);
        check($sformatf("v%0d_grant", idx), (grant_ch.size() == 1) ? 64'(grant_ch[0]) : 64'hDEAD, 64'(v.ch));
        check($sformatf("v%0d_rd_cnt", idx), 64'(rd_addr.size()), v.exp_rd ? 64'd1 : 64'd0);
        if (v.exp_rd && rd_addr.size() > 0)
            check($sformatf("v%0d_rd_addr", idx), 64'(rd_addr[0]), 64'(v.exp_addr));
        check($sformatf("v%0d_wr_cnt", idx), 64'(wr_log.size()), v.exp_wr ? 64'd1 : 64'd0);
        if (v.exp_wr && wr_log.size() > 0) begin
            check($sformatf("v%0d_wr_addr", idx), 64'(wr_log[0].a), 64'(v.exp_addr));
            check($sformatf("v%0d_wr_wea", idx), 64'(wr_log[0].w), 64'(v.exp_wea));
            check($sformatf("v%0d_wr_dina", idx), wr_log[0].d, v.exp_dina);
        end
    endtask

    initial begin
        int k;
        int bad;
        int exp_ptr;
        bit seen;

        checks = 0; errors = 0; multi_err = 0; cyc = 0;
        reset = 1'b0; ram_rst = 1'b0;
        refresh();
        for (int i = 0; i < DEPTH; i++) mem[i] = 64'h0123_4567_89AB_CDEF ^ 64'(i);
        rd1 = 64'd0; douta = 64'd0;

        //             ch  x    y    d      rd wr addr      wea    dina
        vecs[0] = '{0,   9,   0, 8'h40, 1, 1, 16'd1,     8'h02, 64'h0000_0000_0000_4000};
        vecs[1] = '{1,   9,   0, 8'h20, 1, 0, 16'd1,     8'h00, 64'h0};
        vecs[2] = '{3,   9,   0, 8'h80, 1, 1, 16'd1,     8'h02, 64'h0000_0000_0000_8000};
        vecs[3] = '{2, 640,   5, 8'h10, 0, 0, 16'd0,     8'h00, 64'h0};
        vecs[4] = '{1, 639, 479, 8'hFF, 1, 1, 16'd38399, 8'h80, 64'hFF00_0000_0000_0000};
        vecs[5] = '{2,   0, 480, 8'h05, 0, 0, 16'd0,     8'h00, 64'h0};
        vecs[6] = '{0,   0,   1, 8'h01, 1, 1, 16'd80,    8'h01, 64'h0000_0000_0000_0001};
        vecs[7] = '{3,   3,   2, 8'h7F, 1, 1, 16'd160,   8'h08, 64'h0000_0000_7F00_0000};
        vecs[8] = '{0,   3,   2, 8'h7F, 1, 0, 16'd160,   8'h00, 64'h0};

        // reset state
        repeat (3) @(negedge clock);
        check("rst_rden", 64'(rden), 64'd0);
        check("rst_ena", 64'(ena), 64'd0);
        check("rst_wea", 64'(wea), 64'd0);
        check("rst_addra", addra, 64'd0);
        check("rst_dina", dina, 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        reset = 1'b1;
        repeat (2) @(negedge clock);

        // full-frame clear from a one-cycle request
        ram_rst = 1'b1;
        @(negedge clock);
        ram_rst = 1'b0;
        k = 0; bad = 0;
        while (busy && k < DEPTH + 100) begin
            if (addra != 64'(k) || !ena || wea != 8'hFF || dina != 64'd0) bad++;
            k++;
            @(negedge clock);
        end
        check("clear_sweep", 64'(bad), 64'd0);
        check("clear_len", 64'(k), 64'(DEPTH));
        check("clear_busy_off", 64'(busy), 64'd0);
        bad = 0;
        for (int i = 0; i < DEPTH; i++) if (mem[i] != 64'd0) bad++;
        check("clear_mem", 64'(bad), 64'd0);

        // single-sample RMW vectors
        for (int i = 0; i < 9; i++) begin
            apply_vec(i);
            if (i == 2) check("pix9_byte", 64'(mem[1][15:8]), 64'h80);
        end

        // all four channels continuously valid: fair order, fixed spacing
        exp_ptr = (vecs[8].ch + 1) % 4;
        clear_logs();
        multi_err = 0;
        @(negedge clock);
        for (int c = 0; c < 4; c++)
            for (int s = 0; s < 3; s++) push(c, 100 + 8 * c + s, 20, 8'h10 + s);
        repeat (75) @(negedge clock);
        check("rr_grants", 64'(grant_ch.size()), 64'd12);
        bad = 0;
        for (int i = 0; i < grant_ch.size(); i++) begin
            if (grant_ch[i] != (exp_ptr + i) % 4) bad++;
            if (i > 0 && grant_cyc[i] - grant_cyc[i-1] != 5) bad++;
        end
        check("rr_order_spacing", 64'(bad), 64'd0);
        check("rr_one_hot", 64'(multi_err), 64'd0);
        check("rr_writes", 64'(wr_log.size()), 64'd12);

        // clear requested while an RMW is in WAIT
        clear_logs();
        @(negedge clock);
        push(2, 10, 0, 8'h33);
        k = 0;
        while (rd_addr.size() == 0 && k < 20) begin @(negedge clock); k++; end
        check("c6_read_seen", 64'(rd_addr.size()), 64'd1);
        @(negedge clock);
        ram_rst = 1'b1;
        k = 0;
        while (!busy && k < 20) begin @(negedge clock); k++; end
        ram_rst = 1'b0;
        check("c6_busy", 64'(busy), 64'd1);
        check("c6_wr_before_clear", 64'(wr_log.size()), 64'd1);
        if (wr_log.size() > 0) begin
            check("c6_wr_addr", 64'(wr_log[0].a), 64'd1);
            check("c6_wr_wea", 64'(wr_log[0].w), 64'h04);
            check("c6_wr_dina", wr_log[0].d, 64'h0000_0000_0033_0000);
        end
        check("c6_clear_addr0", addra, 64'd0);
        check("c6_clear_wea", 64'(wea), 64'hFF);
        repeat (5) @(negedge clock);
        check("c6_clear_addr5", addra, 64'd5);

        // asynchronous reset mid-sweep aborts at once and leaves the rest of RAM alone
        #2 reset = 1'b0;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_ena", 64'(ena), 64'd0);
        check("abort_addra", addra, 64'd0);
        check("abort_mem_tail", mem[DEPTH-1], 64'hFF00_0000_0000_0000);
        @(negedge clock);
        reset = 1'b1;

        // pointer restarts at channel 0 after reset
        clear_logs();
        @(negedge clock);
        push(3, 1, 0, 8'h66);
        push(1, 0, 0, 8'h55);
        seen = 1'b0;
        repeat (20) @(negedge clock);
        check("post_rst_grants", 64'(grant_ch.size()), 64'd2);
        if (grant_ch.size() == 2) begin
            check("post_rst_first", 64'(grant_ch[0]), 64'd1);
            check("post_rst_second", 64'(grant_ch[1]), 64'd3);
        end
        check("post_rst_wr_cnt", 64'(wr_log.size()), 64'd2);
        if (wr_log.size() == 2) begin
            check("post_rst_wr0", {wr_log[0].w, wr_log[0].d[55:0]}, {8'h01, 56'h55});
            check("post_rst_wr1", {wr_log[1].w, wr_log[1].d[55:0]}, {8'h02, 56'h6600});
        end
        check("final_word0", mem[0], 64'h0000_0000_0000_6655);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
